fib_stream_gen: RTL and testbench

FIB_STREAM_GEN -- requirements
Module: fib_stream_gen

---
 rtl/fib_stream_gen.sv | 165 ++++++++++++++++
 tb/tb_fib_stream_gen.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_stream_gen.sv
// Fibonacci stream generator: emits LANES consecutive terms per valid/ready beat,
// either wrapping modulo 2^W or stopping cleanly at the first overflowing term.
module fib_stream_gen #(
  parameter int W        = 16,
  parameter int LANES    = 2,
  parameter int SAT_STOP = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [W-1:0]       seed0_i,
  input  logic [W-1:0]       seed1_i,
  input  logic [15:0]        len_i,
  input  logic               abort_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [LANES*W-1:0] out_terms_o,
  output logic [2:0]         out_count_o,
  output logic [15:0]        out_index_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               overflow_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     termA_q, termA_d, termB_q, termB_d;
  logic [15:0]      remaining_q, remaining_d, index_q, index_d;
  logic             overflow_q, overflow_d, bWrapped_q, bWrapped_d;
  logic [1:0]       rstSync_q;
  logic             rstSyncN;
  logic [W-1:0]     term [LANES+2];
  logic [LANES+1:0] carry;
  logic [LANES+1:0] wrapped;
  logic [2:0]       baseCount, laneCount;
  logic             satCut;
  logic             xfer;

  // Reset asserts immediately but releases on a clock edge, so the first active edge is clean.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rstSync_q <= 2'b00;
    else      rstSync_q <= {rstSync_q[0], 1'b1};
  end
  assign rstSyncN = rstSync_q[1];

  // Each later term is built from the wrapped W-bit predecessors; carries mark overflow.
  always_comb begin
    logic [W-1:0] prev2, prev1;
    logic [W:0]   sum;
    prev2   = termA_q;
    prev1   = termB_q;
    sum     = '0;
    term[0] = termA_q;
    term[1] = termB_q;
    carry   = '0;
    for (int i = 2; i < LANES + 2; i++) begin
      sum      = {1'b0, prev2} + {1'b0, prev1};
      term[i]  = sum[W-1:0];
      carry[i] = sum[W];
      prev2    = prev1;
      prev1    = sum[W-1:0];
    end
  end

  // Lane 1 is a register, so its overflow has to be remembered from the previous beat.
  always_comb begin
    wrapped    = carry;
    wrapped[1] = bWrapped_q;
  end

  always_comb begin
    baseCount = (remaining_q < 16'(LANES)) ? remaining_q[2:0] : 3'(LANES);
    laneCount = baseCount;
    satCut    = 1'b0;
    if (SAT_STOP != 0) begin
      for (int j = LANES - 1; j >= 0; j--) begin
        if (wrapped[j] && (j < int'(baseCount))) begin
          laneCount = 3'(j);
          satCut    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    out_terms_o = '0;
    for (int i = 0; i < LANES; i++) begin
      if (state_q == RUN && i < int'(laneCount)) out_terms_o[i*W +: W] = term[i];
    end
  end

  assign xfer = (state_q == RUN) && out_ready_i;

  always_comb begin
    state_d     = state_q;
    termA_d     = termA_q;
    termB_d     = termB_q;
    remaining_d = remaining_q;
    index_d     = index_q;
    overflow_d  = overflow_q;
    bWrapped_d  = bWrapped_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          index_d    = '0;
          overflow_d = 1'b0;
          bWrapped_d = 1'b0;
          if (len_i != 16'd0) begin
            termA_d     = seed0_i;
            termB_d     = seed1_i;
            remaining_d = len_i;
            state_d     = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (xfer) begin
          termA_d     = term[LANES];
          termB_d     = term[LANES+1];
          remaining_d = remaining_q - {13'd0, laneCount};
          index_d     = index_q + 16'(LANES);
          bWrapped_d  = carry[LANES+1];
          if (|carry) overflow_d = 1'b1;
          // A truncated beat, or a next lane 0 that already overflowed, ends a saturating run.
          if (remaining_d == 16'd0 || (SAT_STOP != 0 && (satCut || wrapped[LANES])))
            state_d = DONE;
        end
        if (abort_i) state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstSyncN) begin
    if (!rstSyncN) begin
      state_q     <= IDLE;
      termA_q     <= '0;
      termB_q     <= '0;
      remaining_q <= '0;
      index_q     <= '0;
      overflow_q  <= 1'b0;
      bWrapped_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      termA_q     <= termA_d;
      termB_q     <= termB_d;
      remaining_q <= remaining_d;
      index_q     <= index_d;
      overflow_q  <= overflow_d;
      bWrapped_q  <= bWrapped_d;
    end
  end

  assign out_valid_o = (state_q == RUN);
  assign out_count_o = (state_q == RUN) ? laneCount : 3'd0;
  assign out_index_o = index_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_fib_stream_gen.sv
// Bench for fib_stream_gen: a Fibonacci model built from exact (unwrapped) values
// fills a scoreboard that is drained as beats transfer on three differently configured instances.
module tb_fib_stream_gen;

  typedef struct packed {
    logic [31:0] terms;
    logic [2:0]  count;
    logic [15:0] index;
  } beat_t;

  beat_t expQ[$];
  int    vectors = 0;
  int    miscompares = 0;

  logic        clk, rst, outReady, abortIn;
  logic [15:0] len;
  logic        start16, start8s, start8w;
  logic [15:0] seedA16, seedB16;
  logic [7:0]  seedA8, seedB8;

  logic        valid16, busy16, done16, ovf16;
  logic [31:0] terms16;
  logic [2:0]  count16;
  logic [15:0] index16;
  logic        valid8s, busy8s, done8s, ovf8s;
  logic [15:0] terms8s;
  logic [2:0]  count8s;
  logic [15:0] index8s;
  logic        valid8w, busy8w, done8w, ovf8w;
  logic [15:0] terms8w;
  logic [2:0]  count8w;
  logic [15:0] index8w;

  fib_stream_gen #(.W(16), .LANES(2), .SAT_STOP(0)) dut16 (
    .clk(clk), .rst(rst), .start_i(start16), .seed0_i(seedA16), .seed1_i(seedB16),
    .len_i(len), .abort_i(abortIn), .out_valid_o(valid16), .out_ready_i(outReady),
    .out_terms_o(terms16), .out_count_o(count16), .out_index_o(index16),
    .busy_o(busy16), .done_o(done16), .overflow_o(ovf16));

  fib_stream_gen #(.W(8), .LANES(2), .SAT_STOP(1)) dut8s (
    .clk(clk), .rst(rst), .start_i(start8s), .seed0_i(seedA8), .seed1_i(seedB8),
    .len_i(len), .abort_i(abortIn), .out_valid_o(valid8s), .out_ready_i(outReady),
    .out_terms_o(terms8s), .out_count_o(count8s), .out_index_o(index8s),
    .busy_o(busy8s), .done_o(done8s), .overflow_o(ovf8s));

  fib_stream_gen #(.W(8), .LANES(2), .SAT_STOP(0)) dut8w (
    .clk(clk), .rst(rst), .start_i(start8w), .seed0_i(seedA8), .seed1_i(seedB8),
    .len_i(len), .abort_i(abortIn), .out_valid_o(valid8w), .out_ready_i(outReady),
    .out_terms_o(terms8w), .out_count_o(count8w), .out_index_o(index8w),
    .busy_o(busy8w), .done_o(done8w), .overflow_o(ovf8w));

  always #5 clk = ~clk;

  // Exact terms are chunked two per beat; saturation cuts before the first term >= 2^w.
  task automatic pushExpected(input longint s0, input longint s1, input int n, input int w,
                              input bit sat, input int maxBeats);
    longint f[$];
    longint lim, mask, l0, l1;
    int     emit;
    beat_t  bt;
    lim  = longint'(1) << w;
    mask = lim - 1;
    for (int i = 0; i < n; i++) begin
      if (i == 0)      f.push_back(s0);
      else if (i == 1) f.push_back(s1);
      else             f.push_back(f[i-1] + f[i-2]);
    end
    emit = n;
    if (sat) for (int i = n - 1; i >= 0; i--) if (f[i] >= lim) emit = i;
    for (int k = 0; 2 * k < emit && k < maxBeats; k++) begin
      l0       = f[2*k] & mask;
      l1       = (2 * k + 1 < emit) ? (f[2*k+1] & mask) : 64'd0;
      bt.terms = 32'(l0 | (l1 << w));
      bt.count = (2 * k + 1 < emit) ? 3'd2 : 3'd1;
      bt.index = 16'(2 * k);
      expQ.push_back(bt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({valid16, busy16, done16, ovf16} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags got=%b exp=0000", {valid16, busy16, done16, ovf16});
    end
    vectors++;
    if ({terms16, count16, index16} !== 51'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_data got terms=%h cnt=%0d idx=%0d exp all zero", terms16, count16, index16);
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if ({valid16, busy16, valid8s, valid8w} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_release_idle got=%b exp=0000", {valid16, busy16, valid8s, valid8w});
    end
  endtask

  task automatic test_basic();
    int cyc, lastBeat;
    bit sawDone;
    beat_t e;
    expQ.delete();
    pushExpected(1, 1, 10, 16, 1'b0, 99);
    seedA16 = 16'd1; seedB16 = 16'd1; len = 16'd10; outReady = 1'b1;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    vectors++;
    if (valid16 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL first_beat_latency got valid=%b exp=1", valid16);
    end
    cyc = 0; lastBeat = -10; sawDone = 1'b0;
    while (!sawDone && cyc < 60) begin
      if (done16) begin
        sawDone = 1'b1;
        vectors++;
        if (cyc != lastBeat + 1) begin
          miscompares++;
          $display("[TB] FAIL basic_done_timing got=%0d exp=1 cycles after last beat", cyc - lastBeat);
        end
      end else if (valid16 && outReady) begin
        vectors++;
        if (expQ.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL basic_extra_beat got terms=%h exp=no beat", terms16);
        end else begin
          e = expQ.pop_front();
          lastBeat = cyc;
          if ({terms16, count16, index16} !== {e.terms, e.count, e.index}) begin
            miscompares++;
            $display("[TB] FAIL basic_beat got terms=%h cnt=%0d idx=%0d exp terms=%h cnt=%0d idx=%0d",
                     terms16, count16, index16, e.terms, e.count, e.index);
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (!sawDone || expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL basic_complete got done=%b left=%0d exp done=1 left=0", sawDone, expQ.size());
    end
    vectors++;
    if (ovf16 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_overflow got=%b exp=0", ovf16);
    end
  endtask

  task automatic test_short();
    int cyc;
    bit sawDone;
    beat_t e;
    expQ.delete();
    pushExpected(1, 1, 5, 16, 1'b0, 99);
    seedA16 = 16'd1; seedB16 = 16'd1; len = 16'd5; outReady = 1'b1;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    cyc = 0; sawDone = 1'b0;
    while (!sawDone && cyc < 40) begin
      if (done16) sawDone = 1'b1;
      else if (valid16) begin
        vectors++;
        if (expQ.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL short_extra_beat got terms=%h exp=no beat", terms16);
        end else begin
          e = expQ.pop_front();
          if ({terms16, count16, index16} !== {e.terms, e.count, e.index}) begin
            miscompares++;
            $display("[TB] FAIL short_beat got terms=%h cnt=%0d idx=%0d exp terms=%h cnt=%0d idx=%0d",
                     terms16, count16, index16, e.terms, e.count, e.index);
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (!sawDone || expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL short_complete got done=%b left=%0d exp done=1 left=0", sawDone, expQ.size());
    end
    len = 16'd0;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    vectors++;
    if ({done16, valid16} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL len0_done got done,valid=%b exp=10", {done16, valid16});
    end
    @(negedge clk);
    vectors++;
    if ({done16, busy16, valid16} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL len0_return_idle got done,busy,valid=%b exp=000", {done16, busy16, valid16});
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    bit sawDone;
    beat_t e;
    expQ.delete();
    pushExpected(1, 1, 6, 16, 1'b0, 99);
    seedA16 = 16'd1; seedB16 = 16'd1; len = 16'd6;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    cyc = 0; sawDone = 1'b0;
    while (!sawDone && cyc < 40) begin
      outReady = !(cyc >= 1 && cyc <= 3);
      if (done16) sawDone = 1'b1;
      else if (valid16 && !outReady) begin
        vectors++;
        if (expQ.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL stall_extra_beat got terms=%h exp=no beat", terms16);
        end else if ({terms16, count16, index16} !== {expQ[0].terms, expQ[0].count, expQ[0].index}) begin
          miscompares++;
          $display("[TB] FAIL stall_hold got terms=%h idx=%0d exp terms=%h idx=%0d",
                   terms16, index16, expQ[0].terms, expQ[0].index);
        end
      end else if (valid16) begin
        vectors++;
        if (expQ.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL bp_extra_beat got terms=%h exp=no beat", terms16);
        end else begin
          e = expQ.pop_front();
          if ({terms16, count16, index16} !== {e.terms, e.count, e.index}) begin
            miscompares++;
            $display("[TB] FAIL bp_beat got terms=%h cnt=%0d idx=%0d exp terms=%h cnt=%0d idx=%0d",
                     terms16, count16, index16, e.terms, e.count, e.index);
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    outReady = 1'b1;
    vectors++;
    if (!sawDone || expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL bp_complete got done=%b left=%0d exp done=1 left=0", sawDone, expQ.size());
    end
  endtask

  task automatic test_sat_stop();
    int cyc, lastBeat;
    bit sawDone;
    beat_t e;
    expQ.delete();
    pushExpected(1, 1, 20, 8, 1'b1, 99);
    seedA8 = 8'd1; seedB8 = 8'd1; len = 16'd20; outReady = 1'b1;
    start8s = 1'b1;
    @(negedge clk);
    start8s = 1'b0;
    cyc = 0; lastBeat = -10; sawDone = 1'b0;
    while (!sawDone && cyc < 60) begin
      if (done8s) begin
        sawDone = 1'b1;
        vectors++;
        if (cyc != lastBeat + 1) begin
          miscompares++;
          $display("[TB] FAIL sat_done_timing got=%0d exp=1 cycles after last beat", cyc - lastBeat);
        end
      end else if (valid8s) begin
        vectors++;
        if (expQ.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL sat_extra_beat got terms=%h exp=no beat", terms8s);
        end else begin
          e = expQ.pop_front();
          lastBeat = cyc;
          if ({16'h0, terms8s, count8s, index8s} !== {e.terms, e.count, e.index}) begin
            miscompares++;
            $display("[TB] FAIL sat_beat got terms=%h cnt=%0d idx=%0d exp terms=%h cnt=%0d idx=%0d",
                     terms8s, count8s, index8s, e.terms, e.count, e.index);
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (!sawDone || expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL sat_complete got done=%b left=%0d exp done=1 left=0", sawDone, expQ.size());
    end
    vectors++;
    if (ovf8s !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL sat_overflow got=%b exp=1", ovf8s);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    bit sawDone;
    beat_t e;
    expQ.delete();
    pushExpected(1, 1, 20, 8, 1'b0, 99);
    seedA8 = 8'd1; seedB8 = 8'd1; len = 16'd20; outReady = 1'b1;
    start8w = 1'b1;
    @(negedge clk);
    start8w = 1'b0;
    cyc = 0; sawDone = 1'b0;
    while (!sawDone && cyc < 60) begin
      if (done8w) sawDone = 1'b1;
      else if (valid8w) begin
        vectors++;
        if (expQ.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL wrap_extra_beat got terms=%h exp=no beat", terms8w);
        end else begin
          e = expQ.pop_front();
          if ({16'h0, terms8w, count8w, index8w} !== {e.terms, e.count, e.index}) begin
            miscompares++;
            $display("[TB] FAIL wrap_beat got terms=%h cnt=%0d idx=%0d exp terms=%h cnt=%0d idx=%0d",
                     terms8w, count8w, index8w, e.terms, e.count, e.index);
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (!sawDone || expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL wrap_complete got done=%b left=%0d exp done=1 left=0", sawDone, expQ.size());
    end
    vectors++;
    if (ovf8w !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL wrap_overflow got=%b exp=1", ovf8w);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    bit sawDone;
    beat_t e;
    seedA16 = 16'd1; seedB16 = 16'd1; len = 16'd10; outReady = 1'b1;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    vectors++;
    if (valid16 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_running got valid=%b exp=1", valid16);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({valid16, busy16, count16} !== 5'b00000) begin
      miscompares++;
      $display("[TB] FAIL async_reset_drop got valid,busy,cnt=%b exp=00000", {valid16, busy16, count16});
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (valid16 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_no_beat got valid=%b exp=0", valid16);
    end
    expQ.delete();
    pushExpected(2, 3, 4, 16, 1'b0, 99);
    seedA16 = 16'd2; seedB16 = 16'd3; len = 16'd4;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    cyc = 0; sawDone = 1'b0;
    while (!sawDone && cyc < 40) begin
      if (done16) sawDone = 1'b1;
      else if (valid16) begin
        vectors++;
        if (expQ.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL restart_extra_beat got terms=%h exp=no beat", terms16);
        end else begin
          e = expQ.pop_front();
          if ({terms16, count16, index16} !== {e.terms, e.count, e.index}) begin
            miscompares++;
            $display("[TB] FAIL restart_beat got terms=%h cnt=%0d idx=%0d exp terms=%h cnt=%0d idx=%0d",
                     terms16, count16, index16, e.terms, e.count, e.index);
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (!sawDone || expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL restart_complete got done=%b left=%0d exp done=1 left=0", sawDone, expQ.size());
    end
  endtask

  task automatic test_abort();
    beat_t e;
    expQ.delete();
    pushExpected(1, 1, 10, 16, 1'b0, 2);
    seedA16 = 16'd1; seedB16 = 16'd1; len = 16'd10; outReady = 1'b1;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      e = expQ.pop_front();
      vectors++;
      if ({valid16, terms16, count16, index16} !== {1'b1, e.terms, e.count, e.index}) begin
        miscompares++;
        $display("[TB] FAIL abort_beat got valid=%b terms=%h idx=%0d exp valid=1 terms=%h idx=%0d",
                 valid16, terms16, index16, e.terms, e.index);
      end
      if (k == 1) abortIn = 1'b1;
      @(negedge clk);
    end
    abortIn = 1'b0;
    vectors++;
    if ({valid16, busy16, done16} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL abort_idle got valid,busy,done=%b exp=000", {valid16, busy16, done16});
    end
    vectors++;
    if (index16 !== 16'd4) begin
      miscompares++;
      $display("[TB] FAIL abort_delivered_index got=%0d exp=4", index16);
    end
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if ({valid16, done16} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL abort_no_done got valid,done=%b exp=00", {valid16, done16});
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clk = 1'b0; rst = 1'b0; outReady = 1'b1; abortIn = 1'b0; len = 16'd0;
    start16 = 1'b0; start8s = 1'b0; start8w = 1'b0;
    seedA16 = 16'd0; seedB16 = 16'd0; seedA8 = 8'd0; seedB8 = 8'd0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_short();
    test_backpressure();
    test_sat_stop();
    test_wrap();
    test_async_reset();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
